// File: rtl/cen_pll_gen_if.sv
// cen_pll_gen_if: control/config/status bundle for the clock-enable generator.
// Latency: n/a (wires only).
// Backpressure: none; master drives lock/resync/config, slave returns enables and status.
// Ports: locked, resync, cfg_we, cfg_sel, cfg_ch, cfg_data (master->slave); cen, running (slave->master).
interface cen_pll_gen_if #(
  parameter int CHANNELS = 4,
  parameter int ACC_W    = 24
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                locked;
  logic                resync;
  logic                cfg_we;
  logic                cfg_sel;
  logic [CH_W-1:0]     cfg_ch;
  logic [ACC_W-1:0]    cfg_data;
  logic [CHANNELS-1:0] cen;
  logic                running;

  modport master (
    output locked, resync, cfg_we, cfg_sel, cfg_ch, cfg_data,
    input  cen, running
  );

  modport slave (
    input  locked, resync, cfg_we, cfg_sel, cfg_ch, cfg_data,
    output cen, running
  );
endinterface

// File: rtl/cen_pll_gen.sv
// cen_pll_gen: multi-channel fractional clock-enable generator, gated by a debounced PLL lock.
// Latency: locked -> FSM 2 cycles; each cen pulse is registered one cycle after its wrapping add.
// Backpressure: none; config writes always accepted, writes to channels >= CHANNELS are dropped.
// Ports: clk, rst_n (async active-low); bus (cen_pll_gen_if.slave): locked (async), resync,
//        cfg_we/cfg_sel/cfg_ch/cfg_data config write port, cen[CHANNELS] pulses, running status.
// Build option: CEN_PHASE_EN adds per-channel PHASE registers; without it every load value is 0.
module cen_pll_gen #(
  parameter int CHANNELS  = 4,
  parameter int ACC_W     = 24,
  parameter int DEN       = 144000,
  parameter int LOCK_WAIT = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  cen_pll_gen_if.slave  bus
);

  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

  localparam logic [ACC_W:0]   DEN_X    = (ACC_W+1)'(DEN);
  localparam logic [ACC_W-1:0] DEN_A    = ACC_W'(DEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_WAIT - 1);

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_SETTLE    = 2'd1,
    S_RUN       = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_lk_s1;
  logic                r_lk_s2;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_running;
  logic [CHANNELS-1:0] r_cen;
  logic [ACC_W-1:0]    r_inc [CHANNELS];
  logic [ACC_W-1:0]    r_acc [CHANNELS];
`ifdef CEN_PHASE_EN
  logic [ACC_W-1:0]    r_phase [CHANNELS];
  logic [ACC_W-1:0]    w_ph    [CHANNELS];
`endif

  logic [CHANNELS-1:0] w_hit;
  logic [CHANNELS-1:0] w_wr_inc;
  logic [CHANNELS-1:0] w_wrap;
  logic [ACC_W-1:0]    w_inc_c   [CHANNELS];
  logic [ACC_W:0]      w_sum     [CHANNELS];
  logic [ACC_W-1:0]    w_acc_nxt [CHANNELS];
  logic [ACC_W-1:0]    w_load    [CHANNELS];

  // Per-channel decode and accumulate step. Comparing cfg_ch against each
  // channel number means out-of-range channel numbers simply match nothing.
  always_comb begin
    w_hit    = '0;
    w_wr_inc = '0;
    w_wrap   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_hit[i]     = bus.cfg_we && (bus.cfg_ch == CH_W'(i));
      w_wr_inc[i]  = w_hit[i] && !bus.cfg_sel;
      // Rates at or above 1 are clamped so the sum never exceeds 2*DEN.
      w_inc_c[i]   = (r_inc[i] >= DEN_A) ? DEN_A : r_inc[i];
      w_sum[i]     = {1'b0, r_acc[i]} + {1'b0, w_inc_c[i]};
      w_wrap[i]    = (w_sum[i] >= DEN_X);
      w_acc_nxt[i] = w_wrap[i] ? ACC_W'(w_sum[i] - DEN_X) : w_sum[i][ACC_W-1:0];
`ifdef CEN_PHASE_EN
      // A PHASE write in the same cycle as a load is seen by that load.
      w_ph[i]      = (w_hit[i] && bus.cfg_sel) ? bus.cfg_data : r_phase[i];
      w_load[i]    = (w_ph[i] >= DEN_A) ? (w_ph[i] - DEN_A) : w_ph[i];
`else
      w_load[i]    = '0;
`endif
    end
  end

  // Configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_inc[i] <= '0;
`ifdef CEN_PHASE_EN
        r_phase[i] <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_wr_inc[i]) r_inc[i] <= bus.cfg_data;
`ifdef CEN_PHASE_EN
        if (w_hit[i] && bus.cfg_sel) r_phase[i] <= bus.cfg_data;
`endif
      end
    end
  end

  // Lock synchroniser, settle FSM and channel accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_WAIT_LOCK;
      r_lk_s1   <= 1'b0;
      r_lk_s2   <= 1'b0;
      r_cnt     <= '0;
      r_running <= 1'b0;
      r_cen     <= '0;
      for (int i = 0; i < CHANNELS; i++) r_acc[i] <= '0;
    end else begin
      r_lk_s1 <= bus.locked;
      r_lk_s2 <= r_lk_s1;
      r_cen   <= '0;
      case (r_state)
        S_WAIT_LOCK: begin
          r_cnt     <= '0;
          r_running <= 1'b0;
          if (r_lk_s2) r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (!r_lk_s2) begin
            r_state <= S_WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
            r_cnt     <= '0;
            for (int i = 0; i < CHANNELS; i++) r_acc[i] <= w_load[i];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RUN: begin
          // Lock loss beats resync, resync beats the accumulate step.
          if (!r_lk_s2) begin
            r_state   <= S_WAIT_LOCK;
            r_running <= 1'b0;
          end else if (bus.resync) begin
            for (int i = 0; i < CHANNELS; i++) r_acc[i] <= w_load[i];
          end else begin
            for (int i = 0; i < CHANNELS; i++) r_acc[i] <= w_acc_nxt[i];
            r_cen <= w_wrap;
          end
        end
        default: begin
          r_state   <= S_WAIT_LOCK;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  // Masking with the synchronised lock silences cen in the very cycle the
  // loss is seen, one edge before the FSM leaves RUN.
  assign bus.cen     = r_cen & {CHANNELS{r_lk_s2}};
  assign bus.running = r_running;

endmodule
